// File: rtl/stdp_array.sv
// stdp_array: pair-based spike-timing-dependent plasticity for N_PRE
// presynaptic channels converging on one postsynaptic neuron.
//
// Each channel owns one weight register. A saturating timer per channel
// (and one for the post neuron) measures the cycles since the last spike.
// Timers load 1 on a spike, then count up and stick at TMAX ("stale").
//
// Learning is evaluated at every edge using the timer values from before
// that edge:
//   post & pre[i]  : potentiation (LTP) with dt = 0
//   post & !pre[i] : LTP with dt = pre_t[i]
//   pre[i] & !post : depression (LTD) with dt = post_t
// An update is taken only when dt < WIN and the timer is not stale. The step
// size is max(A - (dt >> TAU_SH), 0). The weight arithmetic saturates at
// both rails.
//
// Handshake: upd_valid is a one-cycle, unqualified pulse with no ready. It
// is registered one edge after the evaluating edge. upd_mask is meaningful
// only while upd_valid is high. The consumer must sample it on every cycle
// because there is no back-pressure. Back-to-back events produce
// back-to-back pulses.
//
// Arithmetic uses 32-bit intermediates, so WW and TW must be below 32.

module stdp_array #(
   parameter int N_PRE  = 4,
   parameter int WW     = 8,
   parameter int TW     = 8,
   parameter int WIN    = 16,
   parameter int A_P    = 8,
   parameter int A_M    = 6,
   parameter int TAU_SH = 1,
   localparam int SW    = (N_PRE > 1) ? $clog2(N_PRE) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_PRE-1:0]      pre_spike,
   input  logic                  post_spike,
   input  logic                  learn_en,
   input  logic                  w_load,
   input  logic [SW-1:0]         w_load_sel,
   input  logic [WW-1:0]         w_load_data,
   input  logic [SW-1:0]         w_rd_sel,
   output logic [WW-1:0]         w_rd_data,
   output logic [N_PRE*WW-1:0]   w_all,
   output logic                  upd_valid,
   output logic [N_PRE-1:0]      upd_mask
);

   localparam logic [TW-1:0] TMAX  = '1;
   localparam logic [TW-1:0] T_ONE = TW'(1);
   localparam logic [WW-1:0] WMAX  = '1;
   localparam logic [WW-1:0] W_RST = WW'(1) << (WW - 1);

   // Spike timers and weight state
   logic [TW-1:0]    pre_t [N_PRE];
   logic [TW-1:0]    post_t;
   logic [WW-1:0]    w_q   [N_PRE];

   // Next-state of weights and the per-channel update flags for this edge
   logic [WW-1:0]    w_d   [N_PRE];
   logic [N_PRE-1:0] mask_d;

   // Per-channel classification, kept as vectors so checkers can bind to them
   logic [N_PRE-1:0] ltp_hit;
   logic [N_PRE-1:0] ltd_hit;
   logic [N_PRE-1:0] load_hit;

   // A timer value is usable when it is fresh and inside the window
   function automatic logic in_window(input logic [TW-1:0] t);
      return (t != TMAX) && (32'(t) < 32'(WIN));
   endfunction

   // Step magnitude that decays linearly with dt and floors at zero
   function automatic logic [31:0] step_size(input int amp, input logic [TW-1:0] dt);
      logic [31:0] sh;
      sh = 32'(dt >> TAU_SH);
      return (sh >= 32'(amp)) ? 32'd0 : (32'(amp) - sh);
   endfunction

   // Weight plus step, clamped at the top rail
   function automatic logic [WW-1:0] sat_add(input logic [WW-1:0] w, input logic [31:0] d);
      logic [32:0] s;
      s = {1'b0, 32'(w)} + {1'b0, d};
      return (s > 33'(WMAX)) ? WMAX : s[WW-1:0];
   endfunction

   // Weight minus step, clamped at zero
   function automatic logic [WW-1:0] sat_sub(input logic [WW-1:0] w, input logic [31:0] d);
      logic [31:0] r;
      r = 32'(w) - d;
      return (d > 32'(w)) ? '0 : r[WW-1:0];
   endfunction

   // Post timer: reload on spike, otherwise count up and stick at TMAX
   always_ff @(posedge clk) begin
      if (rst) begin
         post_t <= TMAX;
      end else if (post_spike) begin
         post_t <= T_ONE;
      end else if (post_t != TMAX) begin
         post_t <= post_t + T_ONE;
      end
   end

   // Pre timers: same rule, one per channel, independent of learn_en
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_PRE; i++) begin
         if (rst) begin
            pre_t[i] <= TMAX;
         end else if (pre_spike[i]) begin
            pre_t[i] <= T_ONE;
         end else if (pre_t[i] != TMAX) begin
            pre_t[i] <= pre_t[i] + T_ONE;
         end
      end
   end

   // Classify each channel for this edge: LTP, LTD, load override
   always_comb begin
      ltp_hit  = '0;
      ltd_hit  = '0;
      load_hit = '0;
      for (int i = 0; i < N_PRE; i++) begin
         load_hit[i] = w_load && (w_load_sel == SW'(i));
         if (learn_en) begin
            if (post_spike && pre_spike[i]) begin
               ltp_hit[i] = 1'b1;
            end else if (post_spike) begin
               ltp_hit[i] = in_window(pre_t[i]);
            end else if (pre_spike[i]) begin
               ltd_hit[i] = in_window(post_t);
            end
         end
      end
   end

   // Next weights and update mask; a load wins over learning on its channel
   always_comb begin
      logic [TW-1:0] dt;
      mask_d = '0;
      dt     = '0;
      for (int i = 0; i < N_PRE; i++) begin
         w_d[i] = w_q[i];
         // Coincident spikes use dt = 0; otherwise use the partner's timer
         dt = (post_spike && !pre_spike[i]) ? pre_t[i]
            : (post_spike ? '0 : post_t);
         if (load_hit[i]) begin
            w_d[i] = w_load_data;
         end else if (ltp_hit[i]) begin
            w_d[i]    = sat_add(w_q[i], step_size(A_P, dt));
            mask_d[i] = 1'b1;
         end else if (ltd_hit[i]) begin
            w_d[i]    = sat_sub(w_q[i], step_size(A_M, dt));
            mask_d[i] = 1'b1;
         end
      end
   end

   // Weight registers
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_PRE; i++) begin
         if (rst) begin
            w_q[i] <= W_RST;
         end else begin
            w_q[i] <= w_d[i];
         end
      end
   end

   // Update pulse and mask, one cycle after the evaluating edge
   always_ff @(posedge clk) begin
      if (rst) begin
         upd_valid <= 1'b0;
         upd_mask  <= '0;
      end else begin
         upd_valid <= |mask_d;
         upd_mask  <= mask_d;
      end
   end

   // Registered readback of the selected weight (pre-edge value)
   always_ff @(posedge clk) begin
      if (rst) begin
         w_rd_data <= W_RST;
      end else if (32'(w_rd_sel) < 32'(N_PRE)) begin
         w_rd_data <= w_q[w_rd_sel];
      end else begin
         w_rd_data <= '0;
      end
   end

   // Flat view of all weight registers, no added latency
   always_comb begin
      w_all = '0;
      for (int i = 0; i < N_PRE; i++) begin
         w_all[i*WW +: WW] = w_q[i];
      end
   end

endmodule

// File: tb/tb_stdp_array.sv
// tb_stdp_array: directed vectors for stdp_array at default parameters.
// A table of per-edge records covers LTP, LTD, coincidence, saturation,
// learn_en gating and back-to-back pulses. Hand-written sequences cover
// the learning window edge, reset and load priority.

module tb_stdp_array;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  pre_spike;
   logic        post_spike;
   logic        learn_en;
   logic        w_load;
   logic [1:0]  w_load_sel;
   logic [7:0]  w_load_data;
   logic [1:0]  w_rd_sel;
   logic [7:0]  w_rd_data;
   logic [31:0] w_all;
   logic        upd_valid;
   logic [3:0]  upd_mask;

   int checks = 0;
   int errors = 0;

   stdp_array dut (
      .clk         (clk),
      .rst         (rst),
      .pre_spike   (pre_spike),
      .post_spike  (post_spike),
      .learn_en    (learn_en),
      .w_load      (w_load),
      .w_load_sel  (w_load_sel),
      .w_load_data (w_load_data),
      .w_rd_sel    (w_rd_sel),
      .w_rd_data   (w_rd_data),
      .w_all       (w_all),
      .upd_valid   (upd_valid),
      .upd_mask    (upd_mask)
   );

   // Clock
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  pre;
      logic        post;
      logic        learn;
      logic        ld;
      logic [1:0]  ld_sel;
      logic [7:0]  ld_data;
      logic [1:0]  rd_sel;
      logic [31:0] exp_w;
      logic        exp_v;
      logic [3:0]  exp_m;
      logic [7:0]  exp_rd;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic [3:0] pre, input logic post, input logic learn,
                               input logic ld, input logic [1:0] ld_sel, input logic [7:0] ld_data,
                               input logic [1:0] rd_sel, input logic [31:0] exp_w,
                               input logic exp_v, input logic [3:0] exp_m, input logic [7:0] exp_rd);
      vec_t v;
      v.pre = pre; v.post = post; v.learn = learn; v.ld = ld; v.ld_sel = ld_sel;
      v.ld_data = ld_data; v.rd_sel = rd_sel; v.exp_w = exp_w; v.exp_v = exp_v;
      v.exp_m = exp_m; v.exp_rd = exp_rd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one edge and settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] pre, input logic post, input logic learn,
                        input logic ld, input logic [1:0] ld_sel, input logic [7:0] ld_data,
                        input logic [1:0] rd_sel);
      pre_spike   = pre;
      post_spike  = post;
      learn_en    = learn;
      w_load      = ld;
      w_load_sel  = ld_sel;
      w_load_data = ld_data;
      w_rd_sel    = rd_sel;
   endtask

   task automatic idle(input int n);
      drive(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      for (int k = 0; k < n; k++) begin
         tick();
         check("idle_no_update", upd_valid, 1'b0);
      end
   endtask

   initial begin
      // Table: one row per edge; state carries from row to row
      vecs[0]  = mk(4'b0001, 0, 1, 0, 2'd0, 8'h00, 2'd0, 32'h80808080, 0, 4'b0000, 8'h80);
      vecs[1]  = mk(4'b0000, 0, 1, 0, 2'd0, 8'h00, 2'd0, 32'h80808080, 0, 4'b0000, 8'h80);
      vecs[2]  = mk(4'b0000, 0, 1, 0, 2'd0, 8'h00, 2'd0, 32'h80808080, 0, 4'b0000, 8'h80);
      vecs[3]  = mk(4'b0000, 1, 1, 0, 2'd0, 8'h00, 2'd0, 32'h80808087, 1, 4'b0001, 8'h80);
      vecs[4]  = mk(4'b0000, 0, 1, 0, 2'd0, 8'h00, 2'd0, 32'h80808087, 0, 4'b0000, 8'h87);
      vecs[5]  = mk(4'b0000, 0, 1, 0, 2'd0, 8'h00, 2'd0, 32'h80808087, 0, 4'b0000, 8'h87);
      vecs[6]  = mk(4'b0000, 0, 1, 0, 2'd0, 8'h00, 2'd0, 32'h80808087, 0, 4'b0000, 8'h87);
      vecs[7]  = mk(4'b0000, 0, 1, 0, 2'd0, 8'h00, 2'd0, 32'h80808087, 0, 4'b0000, 8'h87);
      vecs[8]  = mk(4'b0010, 0, 1, 0, 2'd0, 8'h00, 2'd1, 32'h80807C87, 1, 4'b0010, 8'h80);
      vecs[9]  = mk(4'b0000, 0, 1, 0, 2'd0, 8'h00, 2'd1, 32'h80807C87, 0, 4'b0000, 8'h7C);
      vecs[10] = mk(4'b0000, 0, 1, 1, 2'd2, 8'hFE, 2'd2, 32'h80FE7C87, 0, 4'b0000, 8'h80);
      vecs[11] = mk(4'b0000, 0, 1, 1, 2'd3, 8'h02, 2'd2, 32'h02FE7C87, 0, 4'b0000, 8'hFE);
      vecs[12] = mk(4'b0100, 1, 1, 0, 2'd0, 8'h00, 2'd3, 32'h02FF8289, 1, 4'b0111, 8'h02);
      vecs[13] = mk(4'b1000, 0, 1, 0, 2'd0, 8'h00, 2'd3, 32'h00FF8289, 1, 4'b1000, 8'h02);
      vecs[14] = mk(4'b0000, 0, 1, 0, 2'd0, 8'h00, 2'd3, 32'h00FF8289, 0, 4'b0000, 8'h00);
      vecs[15] = mk(4'b0011, 0, 0, 0, 2'd0, 8'h00, 2'd0, 32'h00FF8289, 0, 4'b0000, 8'h89);
      vecs[16] = mk(4'b0000, 1, 0, 1, 2'd1, 8'h55, 2'd1, 32'h00FF5589, 0, 4'b0000, 8'h82);
      vecs[17] = mk(4'b0000, 1, 1, 0, 2'd0, 8'h00, 2'd1, 32'h06FF5C90, 1, 4'b1111, 8'h55);
      vecs[18] = mk(4'b0000, 1, 1, 0, 2'd0, 8'h00, 2'd0, 32'h0CFF6397, 1, 4'b1111, 8'h90);
      vecs[19] = mk(4'b0000, 0, 1, 0, 2'd0, 8'h00, 2'd0, 32'h0CFF6397, 0, 4'b0000, 8'h97);

      // Reset
      rst = 1'b1;
      drive(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      tick();
      tick();
      check("reset_w_all", w_all, 32'h80808080);
      check("reset_valid", upd_valid, 1'b0);
      check("reset_mask", upd_mask, 4'b0000);
      check("reset_rd", w_rd_data, 8'h80);
      rst = 1'b0;

      // Table-driven vectors
      for (int r = 0; r < NV; r++) begin
         drive(vecs[r].pre, vecs[r].post, vecs[r].learn, vecs[r].ld,
               vecs[r].ld_sel, vecs[r].ld_data, vecs[r].rd_sel);
         tick();
         check($sformatf("row%0d_w_all", r), w_all, vecs[r].exp_w);
         check($sformatf("row%0d_valid", r), upd_valid, vecs[r].exp_v);
         if (vecs[r].exp_v)
            check($sformatf("row%0d_mask", r), upd_mask, vecs[r].exp_m);
         check($sformatf("row%0d_rd", r), w_rd_data, vecs[r].exp_rd);
      end

      // Window edge: dt = 15 is the last update (step 1), dt = 16 is ignored
      idle(20);
      drive(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      tick();
      check("win15_pre_no_ltd", upd_valid, 1'b0);
      idle(14);
      drive(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      tick();
      check("win15_w_all", w_all, 32'h0CFF6398);
      check("win15_valid", upd_valid, 1'b1);
      check("win15_mask", upd_mask, 4'b0001);
      idle(20);
      drive(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      tick();
      check("win16_pre_no_ltd", upd_valid, 1'b0);
      idle(15);
      drive(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      tick();
      check("win16_w_all", w_all, 32'h0CFF6398);
      check("win16_valid", upd_valid, 1'b0);

      // Reset mid-run overrides spikes, loads and learn_en
      rst = 1'b1;
      drive(4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 8'h33, 2'd0);
      tick();
      check("midrst_w_all", w_all, 32'h80808080);
      check("midrst_valid", upd_valid, 1'b0);
      check("midrst_mask", upd_mask, 4'b0000);
      check("midrst_rd", w_rd_data, 8'h80);
      rst = 1'b0;
      idle(1);
      check("postrst_w_all", w_all, 32'h80808080);
      // Lone post after reset: pre timers are stale, so nothing learns
      drive(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      tick();
      check("lone_post_valid", upd_valid, 1'b0);
      check("lone_post_w_all", w_all, 32'h80808080);

      // Second reset, then a lone pre: the post timer is stale, so no LTD
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(1);
      drive(4'b0100, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      tick();
      check("lone_pre_valid", upd_valid, 1'b0);
      check("lone_pre_w_all", w_all, 32'h80808080);

      // Load on ch0 wins over an in-window post; other channels still learn
      drive(4'b1011, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      tick();
      check("prio_pre_valid", upd_valid, 1'b0);
      idle(1);
      drive(4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 8'h10, 2'd0);
      tick();
      check("prio_w_all", w_all, 32'h87878710);
      check("prio_valid", upd_valid, 1'b1);
      check("prio_mask", upd_mask, 4'b1110);
      check("prio_rd_old", w_rd_data, 8'h80);
      drive(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0);
      tick();
      check("prio_rd_new", w_rd_data, 8'h10);
      check("prio_pulse_end", upd_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stdp_array.md
STDP_ARRAY -- requirements
Module: stdp_array

Interface
REQ-001 SHALL provide parameter N_PRE, default 4, number of presynaptic channels (1..16).
REQ-002 SHALL provide parameter WW, default 8, weight width in bits.
REQ-003 SHALL provide parameter TW, default 8, spike-timer width in bits.
REQ-004 SHALL provide parameter WIN, default 16, learning window in cycles (WIN < 2^TW-1).
REQ-005 SHALL provide parameters A_P, default 8, and A_M, default 6, which are the peak LTP and LTD step magnitudes.
REQ-006 SHALL provide parameter TAU_SH, default 1, which is the decay right-shift applied to dt.
REQ-007 SHALL provide the port clk, input, width 1, the single clock; all logic updates on its rising edge.
REQ-008 SHALL provide the port rst, input, width 1, the synchronous active-high reset.
REQ-009 SHALL provide the port pre_spike, input, width N_PRE, the per-channel presynaptic spike, sampled each edge.
REQ-010 SHALL provide the port post_spike, input, width 1, the postsynaptic spike.
REQ-011 SHALL provide the port learn_en, input, width 1, which enables weight learning.
REQ-012 SHALL provide the port w_load, input, width 1, a weight-load strobe.
REQ-013 SHALL provide the port w_load_sel, input, width clog2(N_PRE), the channel to load.
REQ-014 SHALL provide the port w_load_data, input, width WW, the load value.
REQ-015 SHALL provide the port w_rd_sel, input, width clog2(N_PRE), the readback channel.
REQ-016 SHALL provide the port w_rd_data, output, width WW, the registered weight of w_rd_sel.
REQ-017 SHALL provide the port w_all, output, width N_PRE*WW, all weights, with channel i at bits [i*WW +: WW].
REQ-018 SHALL provide the port upd_valid, output, width 1, a one-cycle pulse indicating that a learning update occurred.
REQ-019 SHALL provide the port upd_mask, output, width N_PRE, the channels updated, qualified by upd_valid.

Function
REQ-020 SHALL keep a TW-bit timer per pre channel and one for post: a spike at an edge loads 1; otherwise the timer increments and saturates at TMAX=2^TW-1; TMAX means "stale".
REQ-021 SHALL evaluate each channel i at every edge, with learn_en=1, in priority order, using timer values from before the edge.
REQ-022 SHALL, when post_spike and pre_spike[i] are both high, apply LTP with dt=0 and no LTD.
REQ-023 SHALL, when post_spike=1 and pre_spike[i]=0, apply LTP with dt=pre_t[i].
REQ-024 SHALL, when pre_spike[i]=1 and post_spike=0, apply LTD with dt=post_t.
REQ-025 SHALL apply an update only when dt < WIN and the timer is not TMAX.
REQ-026 SHALL compute the LTP delta as max(A_P - (dt>>TAU_SH), 0) and the LTD delta as max(A_M - (dt>>TAU_SH), 0).
REQ-027 SHALL saturate the weight arithmetic to [0, 2^WW-1], with no wrap-around.
REQ-028 SHALL write the weight at the same edge as the spike, and SHALL set upd_mask[i] for every channel meeting REQ-025 even if the delta is 0 or the weight is saturated.
REQ-029 SHALL register upd_valid = |mask for exactly one cycle after the evaluating edge; back-to-back events SHALL produce consecutive pulses.
REQ-030 SHALL give w_load priority over learning on the selected channel at the same edge; upd_mask SHALL not be set for that channel, while other channels learn normally.
REQ-031 SHALL, when learn_en=0, keep the timers running, change no weights except by load, and hold upd_valid at 0.
REQ-032 SHALL register w_rd_data with 1-cycle latency from w_rd_sel, and SHALL reflect a weight written at edge k on w_rd_data after edge k+1.
REQ-033 SHALL take w_all directly from the weight registers, with 0 cycles added latency.

Reset
REQ-034 SHALL, while rst=1 at an edge, set all timers to TMAX, all weights to 2^(WW-1) (0x80 at defaults), w_rd_data to 0x80, and upd_valid and upd_mask to 0.
REQ-035 SHALL make reset override spikes, loads and learn_en, and SHALL, after reset mid-operation, produce no update until new spikes occur.

Verification (default parameters)
REQ-036 SHALL verify LTP: with pre_spike[0] at edge k and post_spike at edge k+3, dt=3 and delta=7, so w0 goes 0x80->0x87 and upd_valid/upd_mask=0001 hold for one cycle.
REQ-037 SHALL verify LTD: with post at edge k and pre_spike[1] at edge k+5, dt=5 and delta=4, so w1 goes 0x80->0x7C.
REQ-038 SHALL verify coincidence/saturation: after a load of w2=0xFE, a simultaneous pre[2]+post gives w2=0xFF with mask bit 2 set and no LTD; w3=0x02 under LTD delta 6 gives 0x00.
REQ-039 SHALL verify the window: with pre[0] then post 16 edges later, no weight change and no upd_valid; post without prior pre leaves the timers stale with no update.
REQ-040 SHALL verify priority: w_load on ch0 with data 0x10 in the same edge as an in-window post gives w0=0x10 and upd_mask bit0=0, while other channels update.
REQ-041 SHALL verify reset: rst asserted mid-run gives all weights 0x80 and timers stale, and a subsequent lone post produces no update.
